// File: rtl/pc_top.sv
// Board-level PC block: 640x480@60 Hz VGA timing/pattern generator plus a
// memory self-test master that writes a word pattern over BUS, reads it back and shows the verdict on led.
module pc_top #(
    parameter int          N_WORDS    = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          READ_LAT   = 2,
    parameter int          BLINK_BITS = 24
) (
    input  logic        clk_50mhz,
    input  logic        rst,
    output logic        vga_red,
    output logic        vga_green,
    output logic        vga_blue,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        led,
    inout  wire  [31:0] BUS,
    output logic [1:0]  Memwrite,
    output logic        Memread,
    output logic [31:0] Addr
);

    localparam int IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);
    localparam logic [2:0]       RD_LAST  = 3'(READ_LAT);

    function automatic logic [31:0] pattern(input logic [IDX_W-1:0] i);
        return 32'hA5A5_0000 | 32'(i);
    endfunction

    function automatic logic [31:0] word_addr(input logic [IDX_W-1:0] i);
        return BASE_ADDR + (32'(i) << 2);
    endfunction

    // VGA counters: pen halves the 50 MHz clock down to the 25 MHz pixel rate
    logic       pen;
    logic [9:0] hc;
    logic [9:0] vc;
    logic       visible;

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            pen <= 1'b0;
            hc  <= '0;
            vc  <= '0;
        end else begin
            pen <= ~pen;
            if (pen) begin
                if (hc == 10'd799) begin
                    hc <= '0;
                    vc <= (vc == 10'd524) ? 10'd0 : vc + 10'd1;
                end else begin
                    hc <= hc + 10'd1;
                end
            end
        end
    end

    assign visible = (hc < 10'd640) && (vc < 10'd480);

    // Output stage: colours and syncs registered from the current counters
    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            vga_red   <= 1'b0;
            vga_green <= 1'b0;
            vga_blue  <= 1'b0;
            vga_hsync <= 1'b1;
            vga_vsync <= 1'b1;
        end else begin
            vga_red   <= visible & hc[6];
            vga_green <= visible & hc[7];
            vga_blue  <= visible & vc[6];
            vga_hsync <= !((hc >= 10'd656) && (hc <= 10'd751));
            vga_vsync <= !((vc >= 10'd490) && (vc <= 10'd491));
        end
    end

    typedef enum logic [2:0] {
        S_WRITE,
        S_WGAP,
        S_READ,
        S_RGAP,
        S_PASS,
        S_FAIL
    } bus_state_t;

    bus_state_t            st;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_nxt;
    logic [2:0]            rd_cnt;
    logic                  rd_ok;
    logic                  bus_oe;
    logic [31:0]           bus_dout;
    logic [BLINK_BITS-1:0] blink_cnt;

    assign idx_nxt = idx + 1'b1;
    assign BUS     = bus_oe ? bus_dout : 32'hzzzz_zzzz;

    // st names the action taken at the next edge; all bus outputs are registers
    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            st        <= S_WRITE;
            idx       <= '0;
            rd_cnt    <= '0;
            rd_ok     <= 1'b0;
            bus_oe    <= 1'b0;
            Memwrite  <= 2'b00;
            Memread   <= 1'b0;
            Addr      <= '0;
            led       <= 1'b0;
            blink_cnt <= '0;
        end else begin
            case (st)
                S_WRITE: begin
                    Memwrite <= 2'b11;
                    bus_oe   <= 1'b1;
                    Addr     <= word_addr(idx);
                    bus_dout <= pattern(idx);
                    st       <= S_WGAP;
                end
                S_WGAP: begin
                    Memwrite <= 2'b00;
                    bus_oe   <= 1'b0;
                    if (idx == LAST_IDX) begin
                        idx <= '0;
                        st  <= S_READ;
                    end else begin
                        idx <= idx_nxt;
                        st  <= S_WRITE;
                    end
                end
                S_READ: begin
                    if (!Memread) begin
                        Memread <= 1'b1;
                        Addr    <= word_addr(idx);
                        rd_cnt  <= 3'd1;
                    end else if (rd_cnt != RD_LAST) begin
                        rd_cnt <= rd_cnt + 3'd1;
                    end else begin
                        // An unknown or floating sample fails the equality and counts as a miss
                        if (BUS == pattern(idx)) rd_ok <= 1'b1;
                        else                     rd_ok <= 1'b0;
                        Memread <= 1'b0;
                        st      <= S_RGAP;
                    end
                end
                S_RGAP: begin
                    if (!rd_ok) begin
                        st <= S_FAIL;
                    end else if (idx == LAST_IDX) begin
                        led <= 1'b1;
                        st  <= S_PASS;
                    end else begin
                        idx     <= idx_nxt;
                        Memread <= 1'b1;
                        Addr    <= word_addr(idx_nxt);
                        rd_cnt  <= 3'd1;
                        st      <= S_READ;
                    end
                end
                S_PASS: begin
                    led <= 1'b1;
                end
                S_FAIL: begin
                    blink_cnt <= blink_cnt + 1'b1;
                    if (&blink_cnt) led <= ~led;
                end
                default: begin
                    st <= S_FAIL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_top.sv
// Randomized scoreboard bench for pc_top: a bus RAM on BUS, an expected-transfer queue
// built from the transfer rules, and a per-cycle VGA/led reference computed from elapsed clocks.
module tb_pc_top;

    localparam int N  = 4;
    localparam int RL = 2;
    localparam int BB = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vga_red, vga_green, vga_blue, vga_hsync, vga_vsync, led;
    wire  [31:0] BUS;
    logic [1:0]  Memwrite;
    logic        Memread;
    logic [31:0] Addr;

    pc_top #(
        .N_WORDS   (N),
        .BASE_ADDR (32'h0000_0000),
        .READ_LAT  (RL),
        .BLINK_BITS(BB)
    ) dut (
        .clk_50mhz(clk),
        .rst      (rst),
        .vga_red  (vga_red),
        .vga_green(vga_green),
        .vga_blue (vga_blue),
        .vga_hsync(vga_hsync),
        .vga_vsync(vga_vsync),
        .led      (led),
        .BUS      (BUS),
        .Memwrite (Memwrite),
        .Memread  (Memread),
        .Addr     (Addr)
    );

    always #10 clk = ~clk;

    // Bench RAM: captures full-word writes, answers reads while enabled
    logic [31:0] mem [16];
    logic        mem_clr = 1'b0;
    logic        mem_en  = 1'b0;
    logic        cor_on  = 1'b0;
    int          cor_idx = 0;
    logic [31:0] cor_val = '0;
    logic [31:0] rd_word;

    always_comb begin
        rd_word = mem[Addr[5:2]];
        if (cor_on && int'(Addr[5:2]) == cor_idx) rd_word = cor_val;
    end

    assign BUS = (mem_en && Memread) ? rd_word : 32'hzzzz_zzzz;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (Memwrite == 2'b11) begin
            mem[Addr[5:2]] <= BUS;
        end
    end

    // Clock edges since the last reset edge (0 = the cycle right after a reset edge)
    int k = -1;
    always @(posedge clk) begin
        if (rst) k <= 0;
        else if (k >= 0) k <= k + 1;
    end

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } xfer_t;

    xfer_t exp_q[$];
    bit    exp_pass = 1'b1;
    int    fail_cyc = 0;
    int    n_total  = 0;
    int    n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    endtask

    // Writes take one cycle plus a gap; reads take READ_LAT cycles plus a gap
    function automatic void plan(input int last_rd, input bit pass);
        xfer_t e;
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            e.wr = 1'b1; e.addr = 32'(4 * i); e.data = 32'hA5A5_0000 + 32'(i); e.cyc = 2 * i;
            exp_q.push_back(e);
        end
        for (int i = 0; i <= last_rd; i++) begin
            e.wr = 1'b0; e.addr = 32'(4 * i); e.data = '0; e.cyc = 2 * N + (RL + 1) * i;
            exp_q.push_back(e);
        end
        exp_pass = pass;
        fail_cyc = 2 * N + (RL + 1) * last_rd + RL + 1;
    endfunction

    function automatic logic led_exp(input int c);
        if (exp_pass) return (c >= 2 * N + (RL + 1) * N) ? 1'b1 : 1'b0;
        if (c < fail_cyc + (1 << BB)) return 1'b0;
        return (((c - fail_cyc) / (1 << BB)) % 2) == 1;
    endfunction

    // Pixel index from elapsed clocks; outputs show the pixel one clock late
    function automatic logic [4:0] vga_exp(input int kk);
        int p, h, v;
        bit vis;
        p   = (kk - 1) / 2;
        h   = p % 800;
        v   = (p / 800) % 525;
        vis = (h < 640) && (v < 480);
        return {vis && ((h / 64) % 2 == 1), vis && ((h / 128) % 2 == 1), vis && ((v / 64) % 2 == 1),
                !(h >= 656 && h < 752), !(v >= 490 && v < 492)};
    endfunction

    bit mr_prev   = 1'b0;
    int rd_len    = 0;
    bit hs_prev   = 1'b1;
    int hs_fall   = -1;
    int hs_widths = 0;

    initial begin
        xfer_t e;
        int c;
        forever begin
            @(negedge clk);
            if (k == 0) begin
                chk("reset_strobes_led", 32'({Memwrite, Memread, led}), 32'h0);
                chk("reset_addr", Addr, 32'h0);
                chk("reset_vga", 32'({vga_red, vga_green, vga_blue, vga_hsync, vga_vsync}), 32'h3);
                mr_prev = 1'b0; rd_len = 0; hs_prev = 1'b1; hs_fall = -1; hs_widths = 0;
            end else if (k > 0) begin
                c = k - 1;
                chk("strobe_legal", 32'((Memwrite == 2'b00 || Memwrite == 2'b11) && !(Memwrite != 2'b00 && Memread)), 32'h1);
                if (Memwrite != 2'b00) begin
                    chk("write_expected", 32'(exp_q.size() != 0), 32'h1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("wr_kind", 32'(e.wr), 32'h1);
                        chk("wr_addr", Addr, e.addr);
                        chk("wr_data", BUS, e.data);
                        chk("wr_cycle", 32'(c), 32'(e.cyc));
                    end
                end
                if (Memread && !mr_prev) begin
                    chk("read_expected", 32'(exp_q.size() != 0), 32'h1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("rd_kind", 32'(e.wr), 32'h0);
                        chk("rd_addr", Addr, e.addr);
                        chk("rd_cycle", 32'(c), 32'(e.cyc));
                    end
                    rd_len = 1;
                end else if (Memread) begin
                    rd_len++;
                end
                if (!Memread && mr_prev) chk("rd_len", 32'(rd_len), 32'(RL));
                mr_prev = Memread;
                chk("led", 32'(led), 32'(led_exp(c)));
                chk("vga", 32'({vga_red, vga_green, vga_blue, vga_hsync, vga_vsync}), 32'(vga_exp(k)));
                if (hs_prev && !vga_hsync) begin
                    if (hs_fall >= 0) chk("hsync_period", 32'(k - hs_fall), 32'd1600);
                    hs_fall = k;
                end
                if (!hs_prev && vga_hsync && hs_fall >= 0) begin
                    chk("hsync_width", 32'(k - hs_fall), 32'd192);
                    hs_widths++;
                end
                hs_prev = vga_hsync;
            end
        end
    end

    // Called just after an edge: reset over the next edge, then release
    task automatic do_reset(input int last_rd, input bit pass, input bit en, input bit con,
                            input int ci, input logic [31:0] cv);
        rst = 1'b1; mem_clr = 1'b1;
        mem_en = en; cor_on = con; cor_idx = ci; cor_val = cv;
        @(posedge clk); #1;
        plan(last_rd, pass);
        rst = 1'b0; mem_clr = 1'b0;
    endtask

    // mode 0 good RAM, 1 floating bus, 2 corrupted word, 3 good RAM with mid-run reset
    task automatic run(input int mode, input int ci, input logic [31:0] cv, input int rst_at, input int len);
        case (mode)
            1:       do_reset(0, 1'b0, 1'b0, 1'b0, 0, '0);
            2:       do_reset(ci, 1'b0, 1'b1, 1'b1, ci, cv);
            default: do_reset(N - 1, 1'b1, 1'b1, 1'b0, 0, '0);
        endcase
        if (mode == 3) begin
            repeat (rst_at + 1) @(posedge clk);
            #1;
            do_reset(N - 1, 1'b1, 1'b1, 1'b0, 0, '0);
        end
        repeat (len) @(posedge clk);
        #1;
        chk("all_xfers_done", 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        int          mode, ci, ra;
        logic [31:0] cv;
        @(posedge clk); #1;
        run(0, 0, '0, 0, 48);
        run(1, 0, '0, 0, 48);
        run(2, 2, 32'h0, 0, 48);
        run(3, 0, '0, 4, 48);
        for (int r = 0; r < 8; r++) begin
            mode = int'($urandom_range(0, 3));
            ci   = int'($urandom_range(0, N - 1));
            cv   = $urandom;
            if (cv == (32'hA5A5_0000 | 32'(ci))) cv = cv ^ 32'h1;
            ra   = int'($urandom_range(0, 19));
            run(mode, ci, cv, ra, 48);
        end
        run(0, 0, '0, 0, 4000);
        chk("hsync_pulses_seen", 32'(hs_widths >= 2), 32'h1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
